booth_radix4_mult: RTL and testbench
====================================

Name: booth_radix4_mult

Overview:
- Signed 32x32 -> 64-bit multiplier using radix-4 (modified) Booth recoding.
- Sixteen partial products are reduced by a carry-save tree and a final carry-propagate adder.
- Result is registered with a valid flag.
- Serves as the datapath multiply unit; one new operand pair may be accepted every cycle (fully pipelined).

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Must be even. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- y  input  32  signed multiplicand (first operand position)
- x  input  32  signed multiplier, Booth-recoded
- in_valid  input  1  x/y are valid this cycle
- sum  output  64  signed product x*y, registered
- out_valid  output  1  sum holds a fresh product

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset: while rst_n=0, sum=0 and out_valid=0 immediately, independent of clk. Any pipeline valid bits clear; in-flight operations are discarded.
- Booth recoding:
  - x is extended with an implicit x[-1]=0.
  - For i=0..15, the digit is formed from (x[2i+1], x[2i], x[2i-1]) and takes a value in {-2,-1,0,+1,+2}.
  - Partial product PP_i = digit * y, sign-extended to 64 bits and shifted left 2i.
  - Negation uses one's complement plus a correction bit injected at bit 2i.
  - Sign-extension compression is permitted if results are bit-exact.
- Reduction: all PP_i plus correction bits are summed modulo 2^64 (CSA/Wallace tree, then final adder). The result must equal the exact two's-complement product; no overflow is possible.
- Timing:
  - When in_valid=1 at a rising edge, the product of x and y at that edge appears on sum after that edge (latency 1).
  - out_valid=1 for exactly the cycles whose sum corresponds to a valid input.
  - Back-to-back inputs yield back-to-back outputs in order.
- in_valid=0: sum holds its last value; out_valid=0.
- Edge cases, all exact:
  - x or y = 0 -> sum = 0.
  - x = -2^31 (top Booth digit -2 path).
  - y = -2^31 (negation of the most negative multiplicand requires a 34-bit intermediate; no truncation).
- Fully synchronous datapath aside from the reset; no latches, no combinational path from inputs to outputs.

Optional Feature:
- Macro BOOTH_PIPE_STAGE_EN.
- Defined: an extra register stage sits between the CSA tree output (sum/carry vectors) and the final adder. Latency becomes 2 cycles, throughput stays 1/cycle, and valid is pipelined alongside. Reset clears the stage and its valid bit.
- Undefined: latency is 1 cycle as above.
- Results are identical in both builds; only timing differs.

Test Plan:
- Reset: assert rst_n=0 mid-stream with pending valid inputs -> sum=0, out_valid=0 immediately; after release, no stale out_valid.
- Basic:
  - x=3, y=-5 -> sum = -15 (0xFFFFFFFFFFFFFFF1).
  - x=0, y=0x12345678 -> sum = 0.
- Extremes:
  - x=y=0x7FFFFFFF -> 0x3FFFFFFF00000001.
  - x=y=-2^31 -> 0x4000000000000000.
  - x=-2^31, y=0x7FFFFFFF -> 0xC000000080000000.
- Throughput: in_valid=1 for 8 consecutive cycles with distinct pairs -> 8 consecutive out_valid cycles, each product matching its input pair in order, at the configured latency (1, or 2 with BOOTH_PIPE_STAGE_EN).
- Random regression: 10000 vectors cycling sign mixes (pos*pos, neg*pos, pos*neg, neg*neg) -> every sum equals the reference 64-bit signed product; report correct/wrong counts, expect wrong=0.

Source files
------------

// File: rtl/booth_radix4_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_mult
// Description : Signed WIDTH x WIDTH -> 2*WIDTH multiplier. Radix-4 Booth
//               recoding produces WIDTH/2 partial products. A 3:2 carry-save
//               tree reduces them, and a final carry-propagate adder sums the
//               result. The unit accepts one operand pair every cycle.
//               Optional macro BOOTH_PIPE_STAGE_EN adds a register stage
//               between the CSA tree and the final adder, so latency is 2.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     y,
  input  logic [WIDTH-1:0]     x,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   sum,
  output logic                 out_valid
);

  localparam int c_NPP  = WIDTH / 2;   // number of Booth partial products
  localparam int c_PW   = 2 * WIDTH;   // product width
  localparam int c_MW   = WIDTH + 2;   // magnitude width: room for 2*(-2^(W-1))
  localparam int c_NOPS = c_NPP + 1;   // partial products plus correction vector

  // Operand count after a given number of 3:2 compression levels.
  function automatic int ops_at(input int lvl);
    int n;
    n = c_NOPS;
    for (int i = 0; i < lvl; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of 3:2 levels needed to reach two operands (sum and carry).
  function automatic int num_levels();
    int n;
    int l;
    n = c_NOPS;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  localparam int c_NLEV = num_levels();

  // Reduction tree storage. Level 0 holds the partial products and the
  // packed negation-correction vector. Each later level holds one CSA stage.
  logic [c_PW-1:0] w_tree [0:c_NLEV][0:c_NOPS-1];

  // Negation correction bits. A '1' sits at bit 2i when digit i is negative.
  logic [c_PW-1:0] w_corr;

  // Multiplicand sign-extended by two bits so that 2*y and -2*y both fit
  // without truncation, including y = -2^(W-1).
  logic [c_MW-1:0] w_ysx;
  assign w_ysx = {{2{y[WIDTH-1]}}, y};

  assign w_corr[c_PW-1:WIDTH] = '0;

  // --------------------------------------------------------------------------
  // Booth recoding and partial-product generation
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < c_NPP; i++) begin : g_pp
      logic [2:0]      w_trip;
      logic            w_one;
      logic            w_two;
      logic            w_neg;
      logic [c_MW-1:0] w_mag;
      logic [c_PW-1:0] w_ext;
      logic [c_PW-1:0] w_oc;

      // Digit i looks at x[2i+1], x[2i] and x[2i-1]. x[-1] is an implicit zero.
      if (i == 0) begin : g_first
        assign w_trip = {x[1], x[0], 1'b0};
      end else begin : g_rest
        assign w_trip = x[2*i+1 : 2*i-1];
      end

      // Digit decode: |d|=1, |d|=2, and sign. Pattern 111 is +0, so it is
      // not treated as negative. This keeps the correction bit clear for a
      // zero digit.
      assign w_one = w_trip[1] ^ w_trip[0];
      assign w_two = (w_trip[2] & ~w_trip[1] & ~w_trip[0]) |
                     (~w_trip[2] & w_trip[1] & w_trip[0]);
      assign w_neg = w_trip[2] & ~(w_trip[1] & w_trip[0]);

      assign w_mag = w_one ? w_ysx :
                     w_two ? {w_ysx[c_MW-2:0], 1'b0} :
                             '0;

      // Sign-extend to the full product width. If the digit is negative,
      // take the one's complement here and add the +1 at bit 2i through
      // w_corr, not at bit 0.
      assign w_ext = {{(c_PW-c_MW){w_mag[c_MW-1]}}, w_mag};
      assign w_oc  = w_neg ? ~w_ext : w_ext;

      assign w_tree[0][i]            = w_oc << (2 * i);
      assign w_corr[2*i+1 : 2*i]     = {1'b0, w_neg};
    end
  endgenerate

  assign w_tree[0][c_NPP] = w_corr;

  // --------------------------------------------------------------------------
  // Carry-save (Wallace-style) reduction: each level groups operands in
  // threes. Each group becomes a sum and a shifted carry. Leftover operands
  // pass through unchanged.
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < c_NLEV; l++) begin : g_lvl
      localparam int c_N = ops_at(l);
      localparam int c_G = c_N / 3;
      localparam int c_M = ops_at(l + 1);

      for (genvar o = 0; o < c_NOPS; o++) begin : g_out
        if (o < 2 * c_G) begin : g_csa
          logic [c_PW-1:0] w_a;
          logic [c_PW-1:0] w_b;
          logic [c_PW-1:0] w_c;
          assign w_a = w_tree[l][3*(o/2)];
          assign w_b = w_tree[l][3*(o/2)+1];
          assign w_c = w_tree[l][3*(o/2)+2];
          if ((o % 2) == 0) begin : g_sum
            assign w_tree[l+1][o] = w_a ^ w_b ^ w_c;
          end else begin : g_carry
            assign w_tree[l+1][o] = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
          end
        end else if (o < c_M) begin : g_pass
          assign w_tree[l+1][o] = w_tree[l][3*c_G + (o - 2*c_G)];
        end else begin : g_zero
          assign w_tree[l+1][o] = '0;
        end
      end
    end
  endgenerate

  logic [c_PW-1:0] w_csa_s;
  logic [c_PW-1:0] w_csa_c;
  assign w_csa_s = w_tree[c_NLEV][0];
  assign w_csa_c = w_tree[c_NLEV][1];

  // Operands and valid bit presented to the final carry-propagate adder.
  logic [c_PW-1:0] w_add_a;
  logic [c_PW-1:0] w_add_b;
  logic            w_add_v;

`ifdef BOOTH_PIPE_STAGE_EN
  logic [c_PW-1:0] r_csa_s;
  logic [c_PW-1:0] r_csa_c;
  logic            r_csa_v;

  // Register the sum/carry vectors between the tree and the final adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csa_s <= '0;
      r_csa_c <= '0;
      r_csa_v <= 1'b0;
    end else begin
      r_csa_v <= in_valid;
      if (in_valid) begin
        r_csa_s <= w_csa_s;
        r_csa_c <= w_csa_c;
      end
    end
  end

  assign w_add_a = r_csa_s;
  assign w_add_b = r_csa_c;
  assign w_add_v = r_csa_v;
`else
  assign w_add_a = w_csa_s;
  assign w_add_b = w_csa_c;
  assign w_add_v = in_valid;
`endif

  logic [c_PW-1:0] r_sum;
  logic            r_valid;

  // Final carry-propagate add and output register. The result holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_add_v;
      if (w_add_v) begin
        r_sum <= w_add_a + w_add_b;
      end
    end
  end

  assign sum       = r_sum;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_radix4_mult
// Description : Scoreboard testbench for booth_radix4_mult. The stimulus
//               process pushes expected products, each tagged with the cycle
//               it should arrive in. A separate monitor pops an entry and
//               compares it whenever out_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_radix4_mult;

`ifdef BOOTH_PIPE_STAGE_EN
  localparam int c_LAT = 2;
`else
  localparam int c_LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] y;
  logic [31:0] x;
  logic        in_valid;
  logic [63:0] sum;
  logic        out_valid;

  booth_radix4_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y         (y),
    .x         (x),
    .in_valid  (in_valid),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
    bit          rnd;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rnd_ok = 0;
  int   rnd_bad = 0;

  // Cycle counter: it increments on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each out_valid cycle must match the oldest expectation in value and arrival cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: got sum=%h out_valid=1, required out_valid=0 (cycle %0d)", sum, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (sum !== e.exp || cyc != e.cyc) begin
          n_bad++;
          if (e.rnd) rnd_bad++;
          $display("FAIL %s: got sum=%h at cycle %0d, required %h at cycle %0d",
                   e.name, sum, cyc, e.exp, e.cyc);
        end else if (e.rnd) begin
          rnd_ok++;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] xv, input logic [31:0] yv,
                       input logic [63:0] ev, input string nm, input bit rnd);
    exp_t e;
    @(posedge clk);
    #1;
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    e.exp  = ev;
    e.cyc  = cyc + c_LAT;
    e.rnd  = rnd;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  typedef struct {
    logic [31:0] xv;
    logic [31:0] yv;
    logic [63:0] ev;
  } vec_t;

  vec_t burst[8];

  initial begin
    rst_n    = 1'b0;
    x        = '0;
    y        = '0;
    in_valid = 1'b0;

    // Reset state
    #3;
    check("reset_sum", sum, 64'h0);
    check("reset_out_valid", {63'h0, out_valid}, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic and extreme directed vectors
    issue(32'd3,        32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "x3_ym5", 1'b0);
    issue(32'd0,        32'h1234_5678, 64'h0,                   "x0", 1'b0);
    issue(32'h1234_5678, 32'd0,        64'h0,                   "y0", 1'b0);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_max", 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min", 1'b0);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "xmin_ymax", 1'b0);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, "xm1_ymin", 1'b0);
    issue(32'd1,        32'h8000_0000, 64'hFFFF_FFFF_8000_0000, "x1_ymin", 1'b0);
    idle(1);
    drain();

    // When idle, sum holds the last product and out_valid stays low.
    idle(3);
    @(negedge clk);
    check("hold_sum", sum, 64'hFFFF_FFFF_8000_0000);
    check("hold_out_valid", {63'h0, out_valid}, 64'h0);

    // Throughput: eight back-to-back distinct pairs
    burst[0] = '{32'd1,         32'd1,         64'h1};
    burst[1] = '{32'd2,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA};
    burst[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
    burst[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    burst[4] = '{32'hFFFF_FFFE, 32'h4000_0000, 64'hFFFF_FFFF_8000_0000};
    burst[5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    burst[6] = '{32'd7,         32'd9,         64'h3F};
    burst[7] = '{32'h1234_5678, 32'd0,         64'h0};
    for (int i = 0; i < 8; i++) begin
      issue(burst[i].xv, burst[i].yv, burst[i].ev, $sformatf("burst%0d", i), 1'b0);
    end
    idle(1);
    drain();

    // Reset asserted mid-stream with results in flight
    issue(32'd5, 32'd6, 64'd30, "pre_rst0", 1'b0);
    issue(32'd7, 32'd8, 64'd56, "pre_rst1", 1'b0);
    issue(32'd9, 32'd10, 64'd90, "pre_rst2", 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_sum", sum, 64'h0);
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {63'h0, out_valid}, 64'h0);
    end

    // Random regression that cycles through the four sign combinations
    for (int k = 0; k < 10000; k++) begin
      logic [31:0] xv;
      logic [31:0] yv;
      longint      a;
      longint      b;
      int          mix;
      mix = k % 4;
      xv  = $urandom;
      yv  = $urandom;
      xv  = mix[0] ? (xv | 32'h8000_0000) : (xv & 32'h7FFF_FFFF);
      yv  = mix[1] ? (yv | 32'h8000_0000) : (yv & 32'h7FFF_FFFF);
      a   = longint'($signed(xv));
      b   = longint'($signed(yv));
      issue(xv, yv, 64'(a * b), "random", 1'b1);
      if ((k % 13) == 12) idle(1);
    end
    idle(1);
    drain();
    idle(2);

    $display("random regression: correct=%0d wrong=%0d", rnd_ok, rnd_bad);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
